// File: rtl/csr_file_pkg.sv
// Shared CSR address map, bit positions and helpers for the machine-mode CSR file.
package csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIP_MEIP_BIT     = 11;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MIP_MSIP_BIT     = 3;

  // Exception PCs are always word aligned on RV32I without compressed support.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose 32-bit halves can be overwritten by software.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  logic [63:0] r_q;

  // A write to either half freezes the whole counter so the written value reads back exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) r_q[31:0]  <= wdata;
      if (wr_hi) r_q[63:32] <= wdata;
    end else if (inc) begin
      r_q <= r_q + 64'd1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap-control responder, EX-stage CSR read/write port, cycle/instret counters.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        instret_i,
  input  logic        irq_external_i,
  input  logic        irq_timer_i,
  input  logic        irq_sw_i,
  input  logic        ie_type_i,
  input  logic        set_cause_i,
  input  logic [3:0]  trap_cause_i,
  input  logic        set_epc_i,
  input  logic [31:0] epc_i,
  input  logic        set_mtval_i,
  input  logic [31:0] mtval_i,
  input  logic        mstatus_ie_clear_i,
  input  logic        mstatus_ie_set_i,
  output logic        mstatus_ie_o,
  output logic        mie_external_o,
  output logic        mie_timer_o,
  output logic        mie_sw_o,
  output logic        mip_external_o,
  output logic        mip_timer_o,
  output logic        mip_sw_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] epc_o
);

  logic        r_mstatus_mie, r_mstatus_mpie;
  logic        r_mie_e, r_mie_t, r_mie_s;
  logic        r_mip_e, r_mip_t, r_mip_s;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mtval;
  logic        r_mcause_int;
  logic [3:0]  r_mcause_code;
  logic [63:0] w_cycle, w_instret;

  logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch, w_wr_mepc;
  logic w_wr_mcause, w_wr_mtval;

  assign w_wr_mstatus  = we_i && (waddr_i == CSR_MSTATUS);
  assign w_wr_mie      = we_i && (waddr_i == CSR_MIE);
  assign w_wr_mtvec    = we_i && (waddr_i == CSR_MTVEC);
  assign w_wr_mscratch = we_i && (waddr_i == CSR_MSCRATCH);
  assign w_wr_mepc     = we_i && (waddr_i == CSR_MEPC);
  assign w_wr_mcause   = we_i && (waddr_i == CSR_MCAUSE);
  assign w_wr_mtval    = we_i && (waddr_i == CSR_MTVAL);

  // Trap commands take priority over a software write to the same register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mcause_int   <= 1'b0;
      r_mcause_code  <= 4'd0;
      r_mepc         <= 32'd0;
      r_mtval        <= 32'd0;
    end else begin
      if (mstatus_ie_clear_i) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mstatus_ie_set_i) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr_mstatus) begin
        r_mstatus_mie  <= wdata_i[MSTATUS_MIE_BIT];
        r_mstatus_mpie <= wdata_i[MSTATUS_MPIE_BIT];
      end

      if (set_cause_i) begin
        r_mcause_int  <= ie_type_i;
        r_mcause_code <= trap_cause_i;
      end else if (w_wr_mcause) begin
        r_mcause_int  <= wdata_i[31];
        r_mcause_code <= wdata_i[3:0];
      end

      if (set_epc_i)      r_mepc <= word_align(epc_i);
      else if (w_wr_mepc) r_mepc <= word_align(wdata_i);

      if (set_mtval_i)     r_mtval <= mtval_i;
      else if (w_wr_mtval) r_mtval <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mie_e    <= 1'b0;
      r_mie_t    <= 1'b0;
      r_mie_s    <= 1'b0;
      r_mip_e    <= 1'b0;
      r_mip_t    <= 1'b0;
      r_mip_s    <= 1'b0;
      r_mtvec    <= 32'd0;
      r_mscratch <= 32'd0;
    end else begin
      r_mip_e <= irq_external_i;
      r_mip_t <= irq_timer_i;
      r_mip_s <= irq_sw_i;
      if (w_wr_mie) begin
        r_mie_e <= wdata_i[MIP_MEIP_BIT];
        r_mie_t <= wdata_i[MIP_MTIP_BIT];
        r_mie_s <= wdata_i[MIP_MSIP_BIT];
      end
      if (w_wr_mtvec)    r_mtvec    <= {wdata_i[31:2], 1'b0, wdata_i[0]};
      if (w_wr_mscratch) r_mscratch <= wdata_i;
    end
  end

  csr_counter64 u_cycle (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (1'b1),
    .wr_lo (we_i && (waddr_i == CSR_MCYCLE)),
    .wr_hi (we_i && (waddr_i == CSR_MCYCLEH)),
    .wdata (wdata_i),
    .q     (w_cycle)
  );

  csr_counter64 u_instret (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (instret_i),
    .wr_lo (we_i && (waddr_i == CSR_MINSTRET)),
    .wr_hi (we_i && (waddr_i == CSR_MINSTRETH)),
    .wdata (wdata_i),
    .q     (w_instret)
  );

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      CSR_MSTATUS:  rdata_o = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
      CSR_MISA:     rdata_o = MISA_VAL;
      CSR_MHARTID:  rdata_o = HART_ID;
      CSR_MIE:      rdata_o = {20'd0, r_mie_e, 3'd0, r_mie_t, 3'd0, r_mie_s, 3'd0};
      CSR_MTVEC:    rdata_o = r_mtvec;
      CSR_MSCRATCH: rdata_o = r_mscratch;
      CSR_MEPC:     rdata_o = r_mepc;
      CSR_MCAUSE:   rdata_o = {r_mcause_int, 27'd0, r_mcause_code};
      CSR_MTVAL:    rdata_o = r_mtval;
      CSR_MIP:      rdata_o = {20'd0, r_mip_e, 3'd0, r_mip_t, 3'd0, r_mip_s, 3'd0};
      CSR_MCYCLE, CSR_CYCLE:       rdata_o = w_cycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     rdata_o = w_cycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rdata_o = w_instret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata_o = w_instret[63:32];
      default:      rdata_o = 32'd0;
    endcase
  end

  assign mstatus_ie_o   = r_mstatus_mie;
  assign mie_external_o = r_mie_e;
  assign mie_timer_o    = r_mie_t;
  assign mie_sw_o       = r_mie_s;
  assign mip_external_o = r_mip_e;
  assign mip_timer_o    = r_mip_t;
  assign mip_sw_o       = r_mip_s;
  assign mtvec_o        = r_mtvec;
  assign epc_o          = r_mepc;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: reads are scoreboarded through an expected queue.
module tb_csr_file;
  import csr_file_pkg::*;

  localparam int W = 32;
  localparam logic [31:0] TB_HART = 32'd5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] raddr_i, waddr_i;
  logic [31:0] rdata_o, wdata_i, epc_i, mtval_i, mtvec_o, epc_o;
  logic        we_i, instret_i, irq_external_i, irq_timer_i, irq_sw_i;
  logic        ie_type_i, set_cause_i, set_epc_i, set_mtval_i;
  logic [3:0]  trap_cause_i;
  logic        mstatus_ie_clear_i, mstatus_ie_set_i, mstatus_ie_o;
  logic        mie_external_o, mie_timer_o, mie_sw_o;
  logic        mip_external_o, mip_timer_o, mip_sw_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  csr_file #(.HART_ID(TB_HART)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .instret_i(instret_i),
    .irq_external_i(irq_external_i), .irq_timer_i(irq_timer_i), .irq_sw_i(irq_sw_i),
    .ie_type_i(ie_type_i), .set_cause_i(set_cause_i), .trap_cause_i(trap_cause_i),
    .set_epc_i(set_epc_i), .epc_i(epc_i),
    .set_mtval_i(set_mtval_i), .mtval_i(mtval_i),
    .mstatus_ie_clear_i(mstatus_ie_clear_i), .mstatus_ie_set_i(mstatus_ie_set_i),
    .mstatus_ie_o(mstatus_ie_o),
    .mie_external_o(mie_external_o), .mie_timer_o(mie_timer_o), .mie_sw_o(mie_sw_o),
    .mip_external_o(mip_external_o), .mip_timer_o(mip_timer_o), .mip_sw_o(mip_sw_o),
    .mtvec_o(mtvec_o), .epc_o(epc_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  // scoreboard: push the expected read value, sample after settling, pop and compare
  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
    raddr_i = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check_val(tag_q.pop_front(), rdata_o, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] rnd;
    rst_i = 1'b1;
    raddr_i = '0; waddr_i = '0; wdata_i = '0; we_i = 1'b0; instret_i = 1'b0;
    irq_external_i = 1'b0; irq_timer_i = 1'b0; irq_sw_i = 1'b0;
    ie_type_i = 1'b0; set_cause_i = 1'b0; trap_cause_i = '0;
    set_epc_i = 1'b0; epc_i = '0; set_mtval_i = 1'b0; mtval_i = '0;
    mstatus_ie_clear_i = 1'b0; mstatus_ie_set_i = 1'b0;

    // reset state
    #11;
    rd(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
    rd(CSR_MCYCLE, 32'd0, "rst_mcycle");
    rd(CSR_MEPC, 32'd0, "rst_mepc");
    check_val("rst_outs", {mstatus_ie_o, mie_external_o, mip_timer_o, mtvec_o, epc_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // parameter reads
    rd(CSR_MISA, 32'h4000_0100, "misa");
    rd(CSR_MHARTID, TB_HART, "mhartid");
    rd(12'h7C0, 32'd0, "unmapped");

    // counter running and software write
    wr(CSR_MCYCLE, 32'd100);
    rd(CSR_MCYCLE, 32'd100, "mcycle_wr");
    tick(); tick(); tick();
    rd(CSR_CYCLE, 32'd103, "cycle_alias");

    // trap round trip
    wr(CSR_MSTATUS, 32'h0000_0008);
    rd(CSR_MSTATUS, 32'h0000_1808, "mstatus_preload");
    set_cause_i = 1'b1; ie_type_i = 1'b1; trap_cause_i = 4'hB;
    set_epc_i = 1'b1; epc_i = 32'h8000_0106; mstatus_ie_clear_i = 1'b1;
    check_val("mie_before_trap", {31'd0, mstatus_ie_o}, 32'd1);
    tick();
    set_cause_i = 1'b0; ie_type_i = 1'b0; set_epc_i = 1'b0; mstatus_ie_clear_i = 1'b0;
    rd(CSR_MCAUSE, 32'h8000_000B, "trap_mcause");
    check_val("trap_epc_o", epc_o, 32'h8000_0104);
    check_val("trap_mie_o", {31'd0, mstatus_ie_o}, 32'd0);
    rd(CSR_MSTATUS, 32'h0000_1880, "trap_mstatus");
    mstatus_ie_set_i = 1'b1;
    tick();
    mstatus_ie_set_i = 1'b0;
    rd(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");
    check_val("mret_mie_o", {31'd0, mstatus_ie_o}, 32'd1);

    // clear wins over set
    mstatus_ie_clear_i = 1'b1; mstatus_ie_set_i = 1'b1;
    tick();
    mstatus_ie_clear_i = 1'b0; mstatus_ie_set_i = 1'b0;
    rd(CSR_MSTATUS, 32'h0000_1880, "clear_wins");

    // collision: trap wins on mepc, then a same-cycle write elsewhere still lands
    set_epc_i = 1'b1; epc_i = 32'h0000_5678;
    wr(CSR_MEPC, 32'h0000_1234);
    rd(CSR_MEPC, 32'h0000_5678, "collide_mepc");
    epc_i = 32'h0000_9ABC;
    rnd = $urandom_range(32'h7FFF_FFFF, 1);
    wr(CSR_MSCRATCH, rnd);
    set_epc_i = 1'b0;
    rd(CSR_MSCRATCH, rnd, "collide_mscratch");
    rd(CSR_MEPC, 32'h0000_9ABC, "collide_mepc2");

    // software writes with field masking
    wr(CSR_MEPC, 32'h0000_1237);
    rd(CSR_MEPC, 32'h0000_1234, "mepc_align");
    wr(CSR_MCAUSE, 32'h8000_00F5);
    rd(CSR_MCAUSE, 32'h8000_0005, "mcause_sw");
    set_mtval_i = 1'b1; mtval_i = 32'hDEAD_BEEF;
    wr(CSR_MTVAL, 32'h1111_1111);
    set_mtval_i = 1'b0;
    rd(CSR_MTVAL, 32'hDEAD_BEEF, "mtval_trap");

    // counter carry
    wr(CSR_MCYCLEH, 32'd0);
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    rd(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_lo_ff");
    tick();
    rd(CSR_MCYCLEH, 32'd1, "mcycleh_carry");
    rd(CSR_MCYCLE, 32'd0, "mcycle_lo_wrap");
    wr(CSR_MINSTRETH, 32'hFFFF_FFFF);
    wr(CSR_MINSTRET, 32'hFFFF_FFFF);
    rd(CSR_MINSTRETH, 32'hFFFF_FFFF, "minstreth_ff");
    tick();
    rd(CSR_MINSTRET, 32'hFFFF_FFFF, "minstret_idle");
    instret_i = 1'b1;
    tick();
    instret_i = 1'b0;
    rd(CSR_MINSTRET, 32'd0, "minstret_wrap");
    rd(CSR_INSTRETH, 32'd0, "instreth_wrap");

    // WARL / read-only
    wr(CSR_MTVEC, 32'hFFFF_FFFF);
    rd(CSR_MTVEC, 32'hFFFF_FFFD, "mtvec_warl");
    check_val("mtvec_o", mtvec_o, 32'hFFFF_FFFD);
    wr(CSR_MIE, 32'hFFFF_FFFF);
    rd(CSR_MIE, 32'h0000_0888, "mie_warl");
    check_val("mie_outs", {29'd0, mie_external_o, mie_timer_o, mie_sw_o}, 32'd7);
    wr(CSR_MIP, 32'hFFFF_FFFF);
    rd(CSR_MIP, 32'd0, "mip_ro");

    // interrupt pending latency
    irq_timer_i = 1'b1;
    #1;
    check_val("mip_t_same_cycle", {31'd0, mip_timer_o}, 32'd0);
    tick();
    check_val("mip_t_next", {31'd0, mip_timer_o}, 32'd1);
    rd(CSR_MIP, 32'h0000_0080, "mip_read");
    irq_sw_i = 1'b1;
    tick();
    rd(CSR_MIP, 32'h0000_0088, "mip_read2");

    // asynchronous reset mid-cycle while counters run
    #2;
    rst_i = 1'b1;
    #1;
    rd(CSR_MCYCLE, 32'd0, "arst_mcycle");
    rd(CSR_MSTATUS, 32'h0000_1800, "arst_mstatus");
    rd(CSR_MINSTRETH, 32'd0, "arst_minstreth");
    check_val("arst_outs",
              {25'd0, mie_external_o, mie_timer_o, mie_sw_o, mip_external_o, mip_timer_o, mip_sw_o, mstatus_ie_o},
              32'd0);
    check_val("arst_mtvec", mtvec_o, 32'd0);
    irq_timer_i = 1'b0; irq_sw_i = 1'b0;
    rst_i = 1'b0;
    tick();

    // final report
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
